// File: rtl/buffer_pkg.sv
// Shared definitions for the FIFO read-side controller: data width default,
// skid-stage state encoding and depth.
package buffer_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned SKID_DEPTH     = 2;
    localparam int unsigned HELD_W         = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/buffer_reader_if.sv
// FIFO read port plus downstream valid/ready handshake of buffer_reader.
// master = the reader itself, slave = FIFO/consumer environment.
interface buffer_reader_if
    import buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  Valid;
    logic                  EMPTY;
    logic [DATA_WIDTH-1:0] FIFO_DATA;
    logic                  READ;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic                  VALID_OUT;
    logic                  READY_IN;

    modport master (
        input  Valid, EMPTY, FIFO_DATA, READY_IN,
        output READ, DATA_OUT, VALID_OUT
    );

    modport slave (
        output Valid, EMPTY, FIFO_DATA, READY_IN,
        input  READ, DATA_OUT, VALID_OUT
    );

endinterface

// File: rtl/buffer_reader_skid.sv
// Two-entry holding stage: captures words at the tail, presents the head,
// and reports how many words it holds.
module buffer_reader_skid
    import buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  head_valid,
    output logic [HELD_W-1:0]     held
);

    skid_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        held    = '0;
        unique case (state_q)
            S_EMPTY: begin
                if (capture) begin
                    head_d  = din;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                held = HELD_W'(1);
                // a capture coinciding with the pop of the only word goes straight to the head
                if (capture && pop) begin
                    head_d = din;
                end else if (capture) begin
                    tail_d  = din;
                    state_d = S_FULL;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                held = HELD_W'(2);
                if (pop) begin
                    head_d = tail_q;
                    if (capture) tail_d = din;
                    else         state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    assign head       = head_q;
    assign head_valid = (state_q != S_EMPTY);

endmodule

// File: rtl/buffer_reader.sv
// Read-side controller for the 8-bit synchronous FIFO with a 2-entry skid stage.
// Optional accepted-word counter: define BUFFER_READER_WORD_COUNT_EN.
module buffer_reader
    import buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    buffer_reader_if.master      bus
`ifdef BUFFER_READER_WORD_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] WORD_COUNT
`endif
);

    logic              inflight_q;
    logic              pop;
    logic [HELD_W-1:0] held;
    logic [2:0]        credit_after;

    assign pop = bus.VALID_OUT & bus.READY_IN;

    // words held plus in flight after this cycle's pop must stay below the stage depth
    assign credit_after = 3'(held) + 3'(inflight_q) - 3'(pop);
    assign bus.READ     = RESET & bus.Valid & ~bus.EMPTY & (credit_after < 3'(SKID_DEPTH));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) inflight_q <= 1'b0;
        else        inflight_q <= bus.READ;
    end

    buffer_reader_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (CLK),
        .rst_n      (RESET),
        .capture    (inflight_q),
        .pop        (pop),
        .din        (bus.FIFO_DATA),
        .head       (bus.DATA_OUT),
        .head_valid (bus.VALID_OUT),
        .held       (held)
    );

`ifdef BUFFER_READER_WORD_COUNT_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)   WORD_COUNT <= '0;
        else if (pop) WORD_COUNT <= WORD_COUNT + CNT_WIDTH'(1);
    end
`endif

endmodule
